// File: rtl/oam_dma_engine.sv
// OAM DMA controller: on a write to the DMA register it copies LEN bytes from
// {page, 8'h00} to DEST_BASE, pacing one byte every CYCLES_PER_BYTE clocks.
module oam_dma_engine #(
    parameter int unsigned LEN             = 160,
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned START_DELAY     = 1,
    parameter logic [15:0] DEST_BASE       = 16'hFE00,
    parameter bit          MIRROR_HIGH_SRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_read_en,
    input  logic [7:0]  dma_rdata,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write_en,
    output logic        busy,
    output logic        cpu_blocked,
    output logic        done
);

    localparam int unsigned IW           = $clog2(LEN + 1);
    localparam int unsigned SW           = $clog2(CYCLES_PER_BYTE);
    localparam int unsigned DELAY_CYCLES = START_DELAY * CYCLES_PER_BYTE;
    localparam int unsigned DW           = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(LEN - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CYCLES_PER_BYTE - 1);
    localparam logic [SW-1:0] WR_SLOT   = SW'(1);
    localparam logic [DW-1:0] LAST_DLY  = DW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam state_t START_STATE = (START_DELAY == 0) ? XFER : DELAY;

    state_t        state, state_n;
    logic [7:0]    page, page_n;
    logic [7:0]    rdata_n;
    logic [IW-1:0] idx, idx_n;
    logic [SW-1:0] slot, slot_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [7:0]    data_q, data_n;
    logic          done_n;
    logic          read_en, write_en;
    logic [7:0]    src_page;
    logic [7:0]    idx_lo;

    generate
        if (IW >= 8) begin : g_idx_wide
            assign idx_lo = idx[7:0];
        end else begin : g_idx_narrow
            assign idx_lo = {{(8 - IW){1'b0}}, idx};
        end
    endgenerate

    assign src_page = (MIRROR_HIGH_SRC && (page >= 8'hE0)) ? (page - 8'h20) : page;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            page      <= '0;
            reg_rdata <= '0;
            idx       <= '0;
            slot      <= '0;
            dcnt      <= '0;
            data_q    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            page      <= page_n;
            reg_rdata <= rdata_n;
            idx       <= idx_n;
            slot      <= slot_n;
            dcnt      <= dcnt_n;
            data_q    <= data_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        page_n   = page;
        rdata_n  = reg_rdata;
        idx_n    = idx;
        slot_n   = slot;
        dcnt_n   = dcnt;
        data_n   = data_q;
        done_n   = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;

        case (state)
            DELAY: begin
                if (dcnt == LAST_DLY) begin
                    state_n = XFER;
                    dcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            XFER: begin
                read_en  = (slot == '0);
                write_en = (slot == WR_SLOT);
                if (slot == '0) begin
                    data_n = dma_rdata;
                end
                if (slot == LAST_SLOT) begin
                    slot_n = '0;
                    idx_n  = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    slot_n = slot + 1'b1;
                end
            end
            default: ;
        endcase

        // A register write restarts from any state and overrides completion,
        // so a byte latched but not yet written is simply never written.
        if (reg_we) begin
            rdata_n = reg_wdata;
            page_n  = reg_wdata;
            idx_n   = '0;
            slot_n  = '0;
            dcnt_n  = '0;
            state_n = START_STATE;
            done_n  = 1'b0;
        end
    end

    assign dma_read_en  = read_en;
    assign oam_write_en = write_en;
    assign dma_addr     = read_en  ? {src_page, idx_lo} : '0;
    assign oam_addr     = write_en ? (DEST_BASE + {8'h00, idx_lo}) : '0;
    assign oam_wdata    = write_en ? data_q : '0;
    assign busy         = (state != IDLE);
    assign cpu_blocked  = (state == XFER);

endmodule
